// File: rtl/board_pkg.sv
// Board-level constants shared by the key input path and game logic.
// Debounce window is derived from the board clock for a 10 ms settle time.
package board_pkg;

  localparam int unsigned BOARD_CLK_HZ    = 50_000_000;
  localparam int unsigned DEBOUNCE_MS     = 10;
  localparam int unsigned KEYS_W          = 4;
  localparam int unsigned DEBOUNCE_CYCLES = (BOARD_CLK_HZ / 1000) * DEBOUNCE_MS;

  // Raw pin level seen while a key is released.
  function automatic logic idle_level(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

  // Convert a raw pin level to active-high "pressed".
  function automatic logic to_active(input logic raw, input bit active_low);
    return active_low ? ~raw : raw;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Single key lane: 2-flop synchronizer, stability counter, accepted level
// and one-cycle press/release pulses, all registered.
module key_debounce
  import board_pkg::idle_level;
  import board_pkg::to_active;
#(
  parameter int unsigned DEBOUNCE_CYCLES = board_pkg::DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_raw_i,
  output logic key_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned      CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic             RAW_IDLE = idle_level(ACTIVE_LOW);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             key_q, key_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             level_c;

  assign level_c = to_active(sync2_q, ACTIVE_LOW);

  // Count consecutive disagreeing cycles; any agreeing cycle restarts from 0.
  always_comb begin
    sync1_d   = key_raw_i;
    sync2_d   = sync1_q;
    cnt_d     = '0;
    stable_d  = stable_q;
    if (level_c != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = level_c;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    key_d     = stable_q;
    press_d   = stable_q & ~key_q;
    release_d = ~stable_q & key_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q   <= RAW_IDLE;
      sync2_q   <= RAW_IDLE;
      cnt_q     <= '0;
      stable_q  <= 1'b0;
      key_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      key_q     <= key_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_o     = key_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/key_conditioner.sv
// Debounces the raw board key pins into clean active-high levels plus
// per-lane press/release pulses; one independent key_debounce per lane.
module key_conditioner #(
  parameter int unsigned KEYS_W          = board_pkg::KEYS_W,
  parameter int unsigned DEBOUNCE_CYCLES = board_pkg::DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [KEYS_W-1:0] keys_raw_i,
  output logic [KEYS_W-1:0] keys_o,
  output logic [KEYS_W-1:0] press_o,
  output logic [KEYS_W-1:0] release_o
);

  for (genvar i = 0; i < KEYS_W; i++) begin : g_lane
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_key_debounce (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .key_raw_i(keys_raw_i[i]),
      .key_o    (keys_o[i]),
      .press_o  (press_o[i]),
      .release_o(release_o[i])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner with DEBOUNCE_CYCLES=4, active-low pins.
// Expected outputs come from a sample-history reference model.
module tb_key_conditioner;

  localparam int unsigned KEYS_W = 4;
  localparam int          DEB    = 4;

  typedef struct packed {
    logic [KEYS_W-1:0] keys;
    logic [KEYS_W-1:0] press;
    logic [KEYS_W-1:0] rel;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [KEYS_W-1:0] keys_raw = '1;
  logic [KEYS_W-1:0] keys, press, rel;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: raw samples from the last two edges, accepted level.
  logic [KEYS_W-1:0] m_h1, m_h2, m_st, m_keys;
  int                m_run[KEYS_W];

  always #5 clk = ~clk;

  key_conditioner #(
    .KEYS_W         (KEYS_W),
    .DEBOUNCE_CYCLES(DEB),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .keys_raw_i(keys_raw),
    .keys_o    (keys),
    .press_o   (press),
    .release_o (rel)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_h1   = '1;
    m_h2   = '1;
    m_st   = '0;
    m_keys = '0;
    for (int i = 0; i < KEYS_W; i++) m_run[i] = 0;
    sb_q.delete();
  endtask

  // One clock edge: predict outputs after the edge, then advance.
  task automatic step();
    exp_t e;
    logic v;
    e.keys  = m_st;
    e.press = m_st & ~m_keys;
    e.rel   = ~m_st & m_keys;
    m_keys  = m_st;
    for (int i = 0; i < KEYS_W; i++) begin
      v = ~m_h2[i];
      if (v == m_st[i]) begin
        m_run[i] = 0;
      end else begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_st[i]  = v;
          m_run[i] = 0;
        end
      end
    end
    m_h2 = m_h1;
    m_h1 = keys_raw;
    @(posedge clk);
    sb_q.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_eq("keys_o", 32'(keys), 32'(e.keys));
      check_eq("press_o", 32'(press), 32'(e.press));
      check_eq("release_o", 32'(rel), 32'(e.rel));
      check_eq("press_release_excl", 32'(press & rel), 32'd0);
    end
  end

  // Step n edges; report the first step where keys[lane]==lvl and the pulse count.
  task automatic run_watch(input int lane, input logic lvl, input int n,
                           output int first, output int pulses);
    first  = -1;
    pulses = 0;
    for (int k = 1; k <= n; k++) begin
      step();
      if (first < 0 && keys[lane] === lvl) first = k;
      if ((lvl ? press[lane] : rel[lane]) === 1'b1) pulses++;
    end
  endtask

  initial begin
    int f, p, f2, p2;
    logic [KEYS_W-1:0] base;
    int glitch[KEYS_W];

    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_keys", 32'(keys), 32'd0);
    check_eq("reset_press", 32'(press), 32'd0);
    check_eq("reset_release", 32'(rel), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // All released: nothing may happen.
    run_watch(0, 1'b1, 20, f, p);
    check_eq("idle_no_press", 32'(f), 32'hffffffff);

    // Lane 0 pressed and held: accepted 6 edges after the sampling edge.
    keys_raw[0] = 1'b0;
    run_watch(0, 1'b1, 10, f, p);
    check_eq("lane0_latency", 32'(f - 1), 32'd6);
    check_eq("lane0_press_pulses", 32'(p), 32'd1);

    // Lane 1: 3-cycle glitch rejected, 4-cycle press accepted.
    keys_raw[1] = 1'b0;
    run_watch(1, 1'b1, 3, f, p);
    keys_raw[1] = 1'b1;
    run_watch(1, 1'b1, 10, f2, p2);
    check_eq("glitch3_press", 32'(p + p2), 32'd0);
    check_eq("glitch3_keys", 32'(keys[1]), 32'd0);
    keys_raw[1] = 1'b0;
    run_watch(1, 1'b1, 4, f, p);
    keys_raw[1] = 1'b1;
    run_watch(1, 1'b1, 6, f2, p2);
    check_eq("press4_latency", 32'(f2), 32'd3);
    check_eq("press4_pulses", 32'(p2), 32'd1);
    run_watch(1, 1'b0, 10, f, p);
    check_eq("press4_released", 32'(keys[1]), 32'd0);

    // Lanes 2 and 3 together.
    keys_raw[3:2] = 2'b00;
    run_watch(2, 1'b1, 10, f, p);
    check_eq("pair_press_latency", 32'(f - 1), 32'd6);
    check_eq("pair_keys", 32'(keys[3:2]), 32'd3);
    keys_raw[3:2] = 2'b11;
    run_watch(2, 1'b0, 10, f, p);
    check_eq("pair_release_latency", 32'(f - 1), 32'd6);
    check_eq("pair_release_pulses", 32'(p), 32'd1);
    check_eq("pair_keys_released", 32'(keys[3:2]), 32'd0);

    // Reset mid-debounce on lane 1 while lane 0 is accepted and held.
    keys_raw[1] = 1'b0;
    run_watch(1, 1'b1, 4, f, p);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("async_reset_keys", 32'(keys), 32'd0);
    check_eq("async_reset_press", 32'(press), 32'd0);
    check_eq("async_reset_release", 32'(rel), 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_watch(0, 1'b1, 12, f, p);
    check_eq("post_reset_latency", 32'(f - 1), 32'd6);
    check_eq("post_reset_press_pulses", 32'(p), 32'd1);
    check_eq("post_reset_keys", 32'(keys[1:0]), 32'd3);

    // Random bounce: slow base level changes with 1..3-cycle glitches.
    base = keys_raw;
    for (int i = 0; i < KEYS_W; i++) glitch[i] = 0;
    for (int c = 0; c < 1000; c++) begin
      for (int i = 0; i < KEYS_W; i++) begin
        if ($urandom_range(0, 39) == 0) base[i] = ~base[i];
        if (glitch[i] > 0) glitch[i]--;
        else if ($urandom_range(0, 7) == 0) glitch[i] = int'($urandom_range(1, 3));
        keys_raw[i] = base[i] ^ (glitch[i] > 0);
      end
      step();
    end

    @(negedge clk);
    #1;
    check_eq("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
